// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared memory-access size codes and store buffer entry layout
package mips_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int ENTRY_W = 32 + 32 + 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// rtl/store_lane_pack.sv - narrows a register value into replicated byte lanes with enables
module store_lane_pack
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        be         = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SIZE_H: begin
                wdata      = {2{data[15:0]}};
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_packer.sv
// rtl/store_packer.sv - store buffer between MEM stage and data memory with lane packing
module store_packer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_be,
    output logic        align_err,
    output logic [31:0] err_addr,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               align_err_q, align_err_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic [31:0]  pk_wdata;
    logic [3:0]   pk_be;
    logic         pk_mis;
    logic         accept, enq, deq;
    store_entry_t new_entry, head;

    store_lane_pack u_pack (
        .addr_lo    (in_addr[1:0]),
        .data       (in_data),
        .size       (in_size),
        .wdata      (pk_wdata),
        .be         (pk_be),
        .misaligned (pk_mis)
    );

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = reset & (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign empty     = (count_q == '0);
    assign accept    = in_valid & in_ready;
    assign enq       = accept & ~pk_mis;
    assign deq       = out_valid & out_ready;

    assign new_entry = '{addr: {in_addr[31:2], 2'b00}, wdata: pk_wdata, be: pk_be};
    assign head      = store_entry_t'(mem_q[rd_ptr_q]);

    assign out_addr  = out_valid ? head.addr  : '0;
    assign out_wdata = out_valid ? head.wdata : '0;
    assign out_be    = out_valid ? head.be    : '0;
    assign align_err = align_err_q;
    assign err_addr  = err_addr_q;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(enq) - CW'(deq);
        align_err_d = accept & pk_mis;
        err_addr_d  = (accept & pk_mis) ? in_addr : err_addr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: doc/store_packer.md
Name: store_packer

Overview:
- Store-side counterpart of the immediate/load extension logic in the MIPS datapath.
  - Load extension widens narrow data to 32 bits.
  - This block narrows a 32-bit register value into byte lanes for data memory.
  - It generates the matching byte enables.
- Sits between the MEM stage and the data memory port.
- Buffers stores in a small FIFO with valid/ready handshakes on both sides.
- Flags misaligned stores to the exception logic.

Parameters:
- DEPTH, 2, number of store buffer entries. Power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  MEM stage presents a store.
- in_ready  output  1  buffer can accept a store this cycle.
- in_addr  input  32  byte address of the store.
- in_data  input  32  GPR[rt] value, right-justified.
- in_size  input  2  00 = sb, 01 = sh, 10 = sw, 11 = reserved.
- out_valid  output  1  head entry is valid toward memory.
- out_ready  input  1  memory accepts the head entry.
- out_addr  output  32  word-aligned address {addr[31:2], 2'b00}.
- out_wdata  output  32  lane-replicated write data.
- out_be  output  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- align_err  output  1  one-cycle pulse: a misaligned store was rejected.
- err_addr  output  32  byte address of the last rejected store.
- empty  output  1  buffer holds no entries; used for drain before syscall/eret.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - count = 0, out_valid = 0, out_addr = 0, out_wdata = 0, out_be = 0.
  - align_err = 0, err_addr = 0, empty = 1.
  - in_ready = 0 while reset is low.
- in_ready:
  - in_ready = (count != DEPTH) while reset is high.
  - No combinational path from out_ready to in_ready.
- Accept condition: in_valid & in_ready.
- Alignment check at accept:
  - sh requires addr[0] == 0.
  - sw requires addr[1:0] == 00.
  - size 11 is always misaligned.
- Misaligned store:
  - Not enqueued.
  - align_err = 1 in the next cycle only; err_addr = in_addr in the same cycle.
  - Back-to-back misaligned stores give consecutive pulses; err_addr tracks the latest.
- Packing, computed at enqueue and stored in the entry:
  - sb: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - sh: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata = data, be = 4'b1111.
  - Bits of in_data above the stored width are ignored.
- Latency: an accepted store appears at the FIFO head one cycle after acceptance when the buffer was empty. There is no same-cycle bypass.
- Dequeue condition: out_valid & out_ready. The head entry must stay stable while out_valid & !out_ready.
- FIFO pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Order is strictly FIFO.
- Simultaneous enqueue and dequeue:
  - Allowed at any count where in_ready = 1; count is unchanged.
  - When full, in_ready = 0, so the same-cycle dequeue frees a slot only for the next cycle.
- Empty/full:
  - out_valid = (count != 0), empty = (count == 0).
  - No accept while full; a dequeue while empty is impossible.
- Reset mid-operation: all buffered stores are discarded, with no memory write. Stores must not be issued during reset.
- out_ready asserted while out_valid = 0 has no effect.

Decomposition:
- Package mips_mem_pkg holds:
  - SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10.
  - Entry width constant: 32 addr + 32 data + 4 be.
  - These are shared with the load-side extender.
- Sub-module store_lane_pack (combinational): (addr[1:0], data, size) -> (wdata, be, misaligned). Instantiated once at the enqueue side.
- FIFO storage and pointers stay in store_packer.

Test Plan:
- sb, addr 0x00000003, data 0x123456AB, out_ready = 1 -> next cycle out_addr = 0x00000000, out_wdata = 0xABABABAB, out_be = 1000, then empty = 1.
- sh, addr 0x00000102, data 0xFFFF8001 -> out_addr = 0x00000100, out_wdata = 0x80018001, out_be = 1100.
- sw, addr 0x00000006 -> no enqueue, align_err pulses for exactly 1 cycle, err_addr = 0x00000006, out_valid stays 0.
- out_ready = 0, three sw (A = 0x10, B = 0x14, C = 0x18) presented back-to-back:
  - A and B are accepted and in_ready drops to 0; C is held.
  - Raise out_ready: A then B drain in order, C is accepted afterward.
- count = 1 with simultaneous enqueue and dequeue over 20 random cycles -> count stable, data order preserved, no lost or duplicated entry.
- Buffer full, reset driven low for 1 cycle -> out_valid = 0, empty = 1, in_ready = 1 after reset returns high; old entries are never presented.
